// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int DIV_W = 3;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    REL_SYS,
    RUN,
    SOFT
  } state_e;

  // Stage counter only ever counts up to max(lock, gap) - 1, so it never wraps.
  function automatic int cnt_width(input int lock_cycles, input int gap_cycles);
    return $clog2(((lock_cycles > gap_cycles) ? lock_cycles : gap_cycles) + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Reset, clock-enable and control signals between the sequencer and the core.
interface pll_seq_if;
  logic soft_rst_req;
  logic lock_lost_clr;
  logic sys_rst_n;
  logic cpu_rst_n;
  logic ready;
  logic ce_14;
  logic ce_7;
  logic ce_3m5;
  logic lock_lost;

  modport master (
    input  soft_rst_req, lock_lost_clr,
    output sys_rst_n, cpu_rst_n, ready, ce_14, ce_7, ce_3m5, lock_lost
  );

  modport slave (
    output soft_rst_req, lock_lost_clr,
    input  sys_rst_n, cpu_rst_n, ready, ce_14, ce_7, ce_3m5, lock_lost
  );
endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: non-blocking assignments keep each flop sampling its predecessor's old value.
  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset release after PLL lock, lock-loss recovery, CPU soft reset and
// phase-aligned 14 / 7 / 3.5 MHz clock enables.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      locked,
  pll_seq_if.master bus
);

  localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             sys_rst_q;
  logic             cpu_rst_q;
  logic             lock_lost_q;
  logic [DIV_W-1:0] div_cnt;
  logic             locked_s;
  logic             lock_drop;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (locked),
    .q    (locked_s)
  );

  // Losing lock only counts once sys_rst_n has been released.
  assign lock_drop = !locked_s && (state inside {REL_SYS, RUN, SOFT});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      sys_rst_q   <= 1'b0;
      cpu_rst_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else if (lock_drop) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      sys_rst_q   <= 1'b0;
      cpu_rst_q   <= 1'b0;
      lock_lost_q <= 1'b1;
    end else begin
      if (bus.lock_lost_clr) lock_lost_q <= 1'b0;
      unique case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (locked_s) state <= STABLE;
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == LOCK_LAST) begin
            state     <= REL_SYS;
            cnt       <= '0;
            sys_rst_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL_SYS, SOFT: begin
          if (cnt == GAP_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            cpu_rst_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.soft_rst_req) begin
            state     <= SOFT;
            cnt       <= '0;
            cpu_rst_q <= 1'b0;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  // Divider restarts from zero on every release so the enables are phase-aligned to it.
  always_ff @(posedge clk) begin
    if (!rst_n || !sys_rst_q) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 1'b1;
  end

  assign bus.sys_rst_n = sys_rst_q;
  assign bus.cpu_rst_n = cpu_rst_q;
  assign bus.ready     = (state == RUN);
  assign bus.lock_lost = lock_lost_q;
  assign bus.ce_14     = sys_rst_q && div_cnt[0];
  assign bus.ce_7      = sys_rst_q && (div_cnt[1:0] == 2'b11);
  assign bus.ce_3m5    = sys_rst_q && (div_cnt == 3'b111);

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a cycle-level reference model.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LSC  = 8;
  localparam int GAP  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic locked;
  int   n_checks = 0;
  int   n_errors = 0;

  pll_seq_if bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_GAP_CYCLES  (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .locked(locked),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: release after LSC+1 consecutive high synchronized samples,
  // then timestamps since release drive the CPU stage and the enable phases.
  logic [SYNC-1:0] m_sync;
  logic m_valid = 1'b0;
  logic m_sys, m_cpu, m_lost;
  int   run_len, since, soft_left, age;

  always @(posedge clk) begin
    logic ls;
    if (!rst_n) begin
      m_sync = '0; m_sys = 0; m_cpu = 0; m_lost = 0;
      run_len = 0; since = 0; soft_left = 0; age = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      ls     = m_sync[SYNC-1];
      m_sync = {m_sync[SYNC-2:0], locked};
      if (!m_sys) begin
        if (bus.lock_lost_clr) m_lost = 0;
        run_len = ls ? run_len + 1 : 0;
        if (run_len == LSC + 1) begin
          m_sys = 1; since = 0; age = 0; run_len = 0;
        end
      end else if (!ls) begin
        m_sys = 0; m_cpu = 0; m_lost = 1;
        run_len = 0; soft_left = 0; since = 0;
      end else begin
        if (bus.lock_lost_clr) m_lost = 0;
        age++;
        if (since < GAP) begin
          since++;
          if (since == GAP) m_cpu = 1;
        end else if (m_cpu && bus.soft_rst_req) begin
          m_cpu = 0; soft_left = GAP;
        end else if (soft_left > 0) begin
          soft_left--;
          if (soft_left == 0) m_cpu = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle_outputs",
            {1'b0, bus.sys_rst_n, bus.cpu_rst_n, bus.ready,
             bus.ce_14, bus.ce_7, bus.ce_3m5, bus.lock_lost},
            {1'b0, m_sys, m_cpu, m_cpu,
             m_sys && (age % 2 == 1), m_sys && (age % 4 == 3),
             m_sys && (age % 8 == 7), m_lost});
    end
  end

  task automatic wait_ready(input int budget);
    int n = 0;
    while (bus.ready !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check("reach_run", 8'(bus.ready), 8'd1);
  endtask

  initial begin
    int c14, c7, c35, bad, low, sys_drop;
    rst_n = 0; locked = 0; bus.soft_rst_req = 0; bus.lock_lost_clr = 0;

    // 1. power-up and staged release
    tick(3);
    check("reset_outputs", {bus.sys_rst_n, bus.cpu_rst_n, bus.ready, bus.ce_14,
                            bus.ce_7, bus.ce_3m5, bus.lock_lost, 1'b0}, 8'h00);
    rst_n = 1;
    tick(7);
    locked = 1;
    tick(10);
    check("sys_before_release", 8'(bus.sys_rst_n), 8'd0);
    tick(1);
    check("sys_release", 8'(bus.sys_rst_n), 8'd1);
    check("ce14_first_cycle", 8'(bus.ce_14), 8'd0);
    tick(1);
    check("ce14_second_cycle", 8'(bus.ce_14), 8'd1);
    tick(2);
    check("cpu_before_release", 8'(bus.cpu_rst_n), 8'd0);
    tick(1);
    check("cpu_release", 8'(bus.cpu_rst_n), 8'd1);
    check("ready_release", 8'(bus.ready), 8'd1);

    // 5. enable cadence over 16 cycles
    c14 = 0; c7 = 0; c35 = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      c14 += int'(bus.ce_14);
      c7  += int'(bus.ce_7);
      c35 += int'(bus.ce_3m5);
      if (bus.ce_3m5 && !(bus.ce_7 && bus.ce_14)) bad++;
    end
    check("ce14_count", 8'(c14), 8'd8);
    check("ce7_count", 8'(c7), 8'd4);
    check("ce3m5_count", 8'(c35), 8'd2);
    check("ce_coincide", 8'(bad), 8'd0);

    // 4. soft reset, second pulse during SOFT ignored
    bus.soft_rst_req = 1;
    tick(1);
    low = 0; sys_drop = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.cpu_rst_n) low++;
      if (!bus.sys_rst_n) sys_drop++;
      bus.soft_rst_req = (i == 1);
      tick(1);
    end
    bus.soft_rst_req = 0;
    check("soft_low_cycles", 8'(low), 8'd4);
    check("soft_sys_held", 8'(sys_drop), 8'd0);

    // 3. lock loss in RUN, then clear the sticky flag
    locked = 0;
    tick(2);
    check("sys_during_sync", 8'(bus.sys_rst_n), 8'd1);
    tick(1);
    check("loss_outputs", {bus.sys_rst_n, bus.cpu_rst_n, bus.ready, bus.ce_14,
                           bus.ce_7, bus.ce_3m5, bus.lock_lost, 1'b0}, 8'h02);
    bus.lock_lost_clr = 1;
    tick(1);
    bus.lock_lost_clr = 0;
    check("lost_cleared", 8'(bus.lock_lost), 8'd0);

    // 2. one-cycle lock glitch while counting stability
    tick(3);
    locked = 1;
    tick(5);
    locked = 0;
    tick(1);
    locked = 1;
    tick(5);
    check("glitch_no_early_release", 8'(bus.sys_rst_n), 8'd0);
    tick(5);
    check("glitch_restart_pending", 8'(bus.sys_rst_n), 8'd0);
    tick(1);
    check("glitch_restart_release", 8'(bus.sys_rst_n), 8'd1);
    check("glitch_lost_clear", 8'(bus.lock_lost), 8'd0);
    wait_ready(20);

    // 6a. soft request and lock loss on the same edge
    locked = 0;
    tick(2);
    bus.soft_rst_req = 1;
    tick(1);
    bus.soft_rst_req = 0;
    check("loss_beats_soft", {6'd0, bus.sys_rst_n, bus.lock_lost}, 8'h01);
    tick(6);
    locked = 1;
    wait_ready(40);

    // 6b. clear and set on the same edge
    locked = 0;
    tick(2);
    bus.lock_lost_clr = 1;
    tick(1);
    bus.lock_lost_clr = 0;
    check("set_beats_clear", 8'(bus.lock_lost), 8'd1);
    bus.lock_lost_clr = 1;
    tick(1);
    bus.lock_lost_clr = 0;
    check("clear_after_set", 8'(bus.lock_lost), 8'd0);

    // 7. rst_n mid-sequence restarts from WAIT_LOCK
    locked = 1;
    wait_ready(40);
    rst_n = 0;
    tick(1);
    check("midrun_reset", {bus.sys_rst_n, bus.cpu_rst_n, bus.ready, bus.ce_14,
                           bus.ce_7, bus.ce_3m5, bus.lock_lost, 1'b0}, 8'h00);
    rst_n = 1;
    tick(10);
    check("restart_pending", 8'(bus.sys_rst_n), 8'd0);
    tick(1);
    check("restart_release", 8'(bus.sys_rst_n), 8'd1);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
